// File: rtl/sram_bank_pkg.sv
// Shared types and constants for the sram_bank block.
package sram_bank_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 7;
    localparam int CNT_W   = 3;

endpackage

// File: rtl/sram_bank_array.sv
// Word-organised storage: byte-lane synchronous write, combinational read.
module sram_bank_array #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32,
    parameter int NB     = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [NB-1:0]     be,
    input  logic [AWIDTH-1:0] idx,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    // No reset on the array; zeroing is done by the controller's clear walk.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/sram_bank.sv
// Single-port SRAM bank with fixed access latency, byte-lane writes,
// alignment/range error reporting and an optional zero-clear after reset.
//
// state | meaning
// CLEAR | writing zero to one word per cycle, ready low
// IDLE  | ready high, accepting a request
// BUSY  | counting down the access latency, access performed at zero
module sram_bank
    import sram_bank_pkg::*;
#(
    parameter int AWIDTH    = 8,
    parameter int DWIDTH    = 32,
    parameter int LATENCY   = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [DWIDTH-1:0]     wdata,
    output logic                  ready,
    output logic                  ack,
    output logic [DWIDTH-1:0]     rdata,
    output logic                  err
);

    localparam int NB = DWIDTH / 8;
    localparam int L  = $clog2(NB);
    localparam logic [31:0] LSB_MASK = 32'((1 << L) - 1);

    if (DWIDTH < 8 || (DWIDTH % 8) != 0 || (NB & (NB - 1)) != 0) begin : g_bad_dwidth
        $error("sram_bank: DWIDTH must be a power-of-two multiple of 8");
    end
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("sram_bank: LATENCY out of range 1..7");
    end
    if (AWIDTH < 1 || AWIDTH + L > 31) begin : g_bad_awidth
        $error("sram_bank: AWIDTH out of range");
    end

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [AWIDTH-1:0]  clr_idx, clr_idx_nxt;

    logic               we_q;
    logic [31:0]        addr_q;
    logic [NB-1:0]      be_q;
    logic [DWIDTH-1:0]  wdata_q;

    logic               capture;
    logic               done;
    logic               bad_addr;
    logic               mem_we;
    logic [NB-1:0]      mem_be;
    logic [AWIDTH-1:0]  mem_idx;
    logic [DWIDTH-1:0]  mem_wdata;
    logic [DWIDTH-1:0]  mem_rdata;

    assign ready    = (state == IDLE);
    assign bad_addr = ((addr_q & LSB_MASK) != 32'd0) || ((addr_q >> (AWIDTH + L)) != 32'd0);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        clr_idx_nxt  = clr_idx;
        capture      = 1'b0;
        done         = 1'b0;
        mem_we       = 1'b0;
        mem_be       = be_q;
        mem_idx      = AWIDTH'(addr_q >> L);
        mem_wdata    = wdata_q;
        case (state)
            CLEAR: begin
                mem_we      = 1'b1;
                mem_be      = '1;
                mem_idx     = clr_idx;
                mem_wdata   = '0;
                clr_idx_nxt = clr_idx + 1'b1;
                if (&clr_idx) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (req) begin
                    capture      = 1'b1;
                    wait_cnt_nxt = CNT_W'(LATENCY - 1);
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt == '0) begin
                    done      = 1'b1;
                    mem_we    = we_q && !bad_addr;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= (INIT_ZERO != 0) ? CLEAR : IDLE;
            wait_cnt <= '0;
            clr_idx  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            clr_idx  <= clr_idx_nxt;
            if (capture) begin
                we_q    <= we;
                addr_q  <= addr;
                be_q    <= be;
                wdata_q <= wdata;
            end
            ack <= done;
            err <= done && bad_addr;
            // rdata only moves on an ack: data for a good read, zero otherwise.
            if (done) begin
                rdata <= (!we_q && !bad_addr) ? mem_rdata : '0;
            end
        end
    end

    sram_bank_array #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH),
        .NB     (NB)
    ) u_array (
        .clk    (clk),
        .we     (mem_we),
        .be     (mem_be),
        .idx    (mem_idx),
        .wdata  (mem_wdata),
        .rdata  (mem_rdata)
    );

endmodule
